// File: rtl/load_store_unit.sv
// Load/store unit: turns single load/store requests into one transaction on a word-wide data bus.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being aligned down.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic [1:0]  size;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic        in_req;

  // Undefined encodings fall through to word accesses.
  function automatic logic [1:0] decode_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: decode_size = SZ_B;
      3'b001, 3'b101: decode_size = SZ_H;
      default:        decode_size = SZ_W;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (decode_size(f3))
      SZ_H:    is_misaligned = a[0];
      SZ_W:    is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction
`endif

  // Lane selection forces H/W down to natural alignment, so misaligned accesses are aligned when not trapped.
  always_comb begin
    size = decode_size(funct3_q);
    case (size)
      SZ_B:    lane = addr_q[1:0];
      SZ_H:    lane = {addr_q[1], 1'b0};
      default: lane = 2'b00;
    endcase
    byte_sel = bus_rdata[{lane, 3'b000} +: 8];
    half_sel = bus_rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B: begin
        load_data  = funct3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        be         = 4'b0001 << lane;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        load_data  = funct3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        be         = 4'b0011 << lane;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        load_data  = bus_rdata;
        be         = 4'hF;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (mem_read || mem_write) begin
          addr_d   = addr;
          wdata_d  = wdata;
          funct3_d = funct3;
          we_d     = mem_write;
          state_d  = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(funct3, addr[1:0])) begin
            state_d    = DONE;
            misalign_d = 1'b1;
            rdata_d    = 32'd0;
          end
`endif
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = DONE;
          cnt_d   = 8'd0;
          rdata_d = we_q ? 32'd0 : load_data;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = DONE;
          cnt_d     = 8'd0;
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      funct3_q  <= 3'd0;
      we_q      <= 1'b0;
      cnt_q     <= 8'd0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign in_req    = (state_q == REQ);
  assign stall     = reset & (in_req | ((state_q == IDLE) & (mem_read | mem_write)));
  assign bus_req   = in_req;
  assign bus_we    = in_req & we_q;
  assign bus_be    = in_req ? be : 4'b0000;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = lane_wdata;
  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = misalign_q;
`else
  assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model, randomized and directed accesses.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_mis, exp_err, exp_rdv, exp_we, exp_wchk;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access width in bytes, natural alignment, lane arithmetic.
  function automatic int unsigned model_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: model_size = 1;
      3'b001, 3'b101: model_size = 2;
      default:        model_size = 4;
    endcase
  endfunction

  function automatic logic [31:0] model_eff(input logic [2:0] f, input logic [31:0] a);
    model_eff = a - (a % model_size(f));
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f, input logic [31:0] a);
    model_misaligned = (a % model_size(f)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
    int unsigned n;
    n = model_size(f);
    model_be = 4'(((1 << n) - 1) << (model_eff(f, a) % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] w);
    int unsigned n;
    n = model_size(f);
    model_wdata = 32'd0;
    for (int i = 0; i < 4; i++) model_wdata[8*i +: 8] = w[8*(i % n) +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int unsigned n;
    longint unsigned v, mask;
    n = model_size(f);
    v = longint'(d) >> (8 * (model_eff(f, a) % 4));
    if (n < 4) begin
      mask = (64'd1 << (8 * n)) - 1;
      v = v & mask;
      if (!f[2] && v[8*n-1]) v = v | (~mask);
    end
    model_load = v[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic setExp(input logic s, input logic rq, input logic mi, input logic er,
                        input logic rv, input logic [31:0] rd, input logic we,
                        input logic [31:0] ba, input logic [3:0] be,
                        input logic [31:0] wd, input logic wc);
    exp_stall = s;  exp_req = rq;  exp_mis = mi;  exp_err = er;
    exp_rdv = rv;   exp_rdata = rd; exp_we = we;  exp_addr = ba;
    exp_be = be;    exp_wdata = wd; exp_wchk = wc;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks every cycle on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("stall", 32'(stall), 32'(exp_stall));
      checkOutput("bus_req", 32'(bus_req), 32'(exp_req));
      checkOutput("misalign", 32'(misalign), 32'(exp_mis));
      checkOutput("bus_err", 32'(bus_err), 32'(exp_err));
      if (exp_req) begin
        checkOutput("bus_addr", bus_addr, exp_addr);
        checkOutput("bus_be", 32'(bus_be), 32'(exp_be));
        checkOutput("bus_we", 32'(bus_we), 32'(exp_we));
        if (exp_wchk) checkOutput("bus_wdata", bus_wdata, exp_wdata);
      end
      if (exp_rdv) checkOutput("rdata", rdata, exp_rdata);
    end
  end

  // One access: IDLE cycle, REQ cycles (ack on REQ cycle index ack_dly), DONE, then one idle gap cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int ack_dly, input logic [31:0] brd);
    bit mis, err, ld;
    logic [31:0] lv;
    ld  = !wr;
    err = (ack_dly >= TO);
    lv  = model_load(f3, a, brd);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = model_misaligned(f3, a);
`else
    mis = 1'b0;
`endif
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
    setExp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    mem_read = 0; mem_write = 0; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (mis) begin
      bus_ack = 1'($urandom % 2);
      mem_read = 1'($urandom % 2); mem_write = 1'($urandom % 2);
      setExp(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step();
    end else begin
      for (int k = 0; k < TO; k++) begin
        bus_ack   = (k == ack_dly);
        bus_rdata = (k == ack_dly) ? brd : $urandom;
        setExp(1, 1, 0, 0, 0, 0, wr, model_eff(f3, a) & ~32'd3, model_be(f3, a),
               model_wdata(f3, wd), wr);
        step();
        if (k == ack_dly) break;
      end
      bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
      mem_read = 1'($urandom % 2); mem_write = 1'($urandom % 2);
      setExp(0, 0, 0, err, ld || err, err ? 32'd0 : lv, 0, 0, 0, 0, 0);
      step();
    end
    mem_read = 0; mem_write = 0; bus_ack = 1'($urandom % 2);
    setExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] rw;
    // Hand-computed values pinning the reference model.
    checkOutput("pin_lb", model_load(3'b000, 32'h103, 32'h80FF0011), 32'hFFFFFF80);
    checkOutput("pin_lbu", model_load(3'b100, 32'h103, 32'h80FF0011), 32'h00000080);
    checkOutput("pin_lw", model_load(3'b010, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
    checkOutput("pin_sh_be", 32'(model_be(3'b001, 32'h22)), 32'h0000000C);
    checkOutput("pin_sh_wd", model_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    checkOutput("pin_sh_ad", model_eff(3'b001, 32'h22) & ~32'd3, 32'h00000020);
    checkOutput("pin_lw102_be", 32'(model_be(3'b010, 32'h102)), 32'h0000000F);
    checkOutput("pin_lw102_ad", model_eff(3'b010, 32'h102), 32'h00000100);

    // Reset with a pending load request: stall must stay low.
    reset = 0; mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h40; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    @(posedge clk); #1;
    setExp(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    step();
    step();
    reset = 1; mem_read = 0;
    setExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("[TB] directed accesses");
    applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF0011);
    applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0011);
    applyStimulus(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 0, 32'h0);
    applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 10, 32'h12345678);
    applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'hCAFEF00D);
    applyStimulus(1, 1, 3'b000, 32'h31, 32'h000000A5, 2, 32'h0);
    applyStimulus(1, 0, 3'b011, 32'h44, 32'h0, 3, 32'h0BADC0DE);
    applyStimulus(1, 0, 3'b101, 32'h12, 32'h0, 0, 32'h8001FFFF);

    $display("[TB] reset during REQ");
    mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h40; bus_ack = 0;
    setExp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    mem_read = 0;
    setExp(1, 1, 0, 0, 0, 0, 0, 32'h40, 4'hF, 0, 0);
    step();
    @(negedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    setExp(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1;
    setExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    applyStimulus(0, 1, 3'b010, 32'h8, 32'h55AA33CC, 1, 32'h0);

    $display("[TB] randomized accesses");
    for (int t = 0; t < 200; t++) begin
      rw = 2'($urandom_range(1, 3));
      applyStimulus(rw[0], rw[1], 3'($urandom), $urandom & 32'h0000_0FFF, $urandom,
                    int'($urandom_range(0, TO + 1)), $urandom);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
